// File: rtl/run_monitor_pkg.sv
// Shared types and counter helpers for the run controller / cycle profiler.
package run_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DUMP_C,
        DUMP_M,
        DONE
    } state_t;

    function automatic logic [63:0] all_ones(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        return (v == all_ones(w)) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/run_monitor_ch.sv
// One monitored CPU channel: drives start_work and captures its finishing cycle.
module run_monitor_ch
    import run_monitor_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             active,
    input  logic             abort,
    input  logic             end_work,
    input  logic [CNT_W-1:0] cnt,
    output logic             start_work,
    output logic             fin,
    output logic [CNT_W-1:0] count
);

    logic hit;

    assign hit = active && !fin && end_work;

    // A disabled channel is marked finished at load so the all-finished check ignores it.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_work <= 1'b0;
            fin        <= 1'b0;
            count      <= '0;
        end else if (load) begin
            start_work <= en;
            fin        <= !en;
            count      <= '0;
        end else if (hit) begin
            start_work <= 1'b0;
            fin        <= 1'b1;
            count      <= cnt;
        end else if (abort) begin
            start_work <= 1'b0;
            if (!fin) begin
                fin   <= 1'b1;
                count <= CNT_W'(all_ones(CNT_W));
            end
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run controller: starts CPU channels, profiles run lengths, then sequences dump pulses.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 0,
    parameter int DUMP_CYCLES = 1,
    parameter int DUMP_MEM    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [N_CH-1:0]       ch_en,
    output logic [N_CH-1:0]       start_work,
    input  logic [N_CH-1:0]       end_work,
    output logic                  c_dump,
    output logic                  m_dump,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [N_CH*CNT_W-1:0] cycles_ch,
    output logic [CNT_W-1:0]      total_cycles
);

    localparam int DW = (DUMP_CYCLES > 1) ? $clog2(DUMP_CYCLES) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DW-1:0]     dcnt;
    logic [N_CH-1:0]   fin;
    logic              load;
    logic              active;
    logic              abort;
    logic              all_done;

    assign load     = (state == IDLE) && start;
    assign active   = (state == RUN);
    // A channel whose end_work is high this cycle finishes now, so count it as done already.
    assign all_done = &(fin | end_work);
    assign abort    = active && (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT)) && !all_done;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        run_monitor_ch #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .load      (load),
            .en        (ch_en[i]),
            .active    (active),
            .abort     (abort),
            .end_work  (end_work[i]),
            .cnt       (cnt),
            .start_work(start_work[i]),
            .fin       (fin[i]),
            .count     (cycles_ch[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            dcnt         <= '0;
            c_dump       <= 1'b0;
            m_dump       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            total_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt          <= CNT_W'(1);
                        total_cycles <= '0;
                        timeout      <= 1'b0;
                        busy         <= 1'b1;
                        if (ch_en == '0) begin
                            state  <= DUMP_C;
                            c_dump <= 1'b1;
                            dcnt   <= '0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= CNT_W'(sat_inc(64'(cnt), CNT_W));
                    if (all_done) begin
                        total_cycles <= cnt;
                        state        <= DUMP_C;
                        c_dump       <= 1'b1;
                        dcnt         <= '0;
                    end else if (abort) begin
                        timeout      <= 1'b1;
                        total_cycles <= CNT_W'(TIMEOUT);
                        state        <= DUMP_C;
                        c_dump       <= 1'b1;
                        dcnt         <= '0;
                    end
                end
                DUMP_C: begin
                    if (dcnt == DW'(DUMP_CYCLES - 1)) begin
                        c_dump <= 1'b0;
                        dcnt   <= '0;
                        if (DUMP_MEM != 0) begin
                            m_dump <= 1'b1;
                            state  <= DUMP_M;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DUMP_M: begin
                    if (dcnt == DW'(DUMP_CYCLES - 1)) begin
                        m_dump <= 1'b0;
                        dcnt   <= '0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_monitor.sv
// Drives three differently configured run_monitor instances with shared stimulus.
module tb_run_monitor;

    localparam int TO_P[3] = '{0, 100, 0};
    localparam int W_P[3]  = '{32, 32, 4};
    localparam int DC_P[3] = '{1, 3, 2};
    localparam int DM_P[3] = '{1, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start;
    logic [1:0] ch_en, end_work;

    logic [1:0]  sw [3];
    logic        cd [3], md [3], bz [3], dn [3], tmo [3];
    logic [63:0] cyc_a, cyc_b;
    logic [7:0]  cyc_c;
    logic [31:0] tot_a, tot_b;
    logic [3:0]  tot_c;

    int checks = 0, failures = 0;

    run_monitor #(.N_CH(2), .CNT_W(32), .TIMEOUT(0), .DUMP_CYCLES(1), .DUMP_MEM(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .ch_en(ch_en), .start_work(sw[0]),
        .end_work(end_work), .c_dump(cd[0]), .m_dump(md[0]), .busy(bz[0]), .done(dn[0]),
        .timeout(tmo[0]), .cycles_ch(cyc_a), .total_cycles(tot_a));
    run_monitor #(.N_CH(2), .CNT_W(32), .TIMEOUT(100), .DUMP_CYCLES(3), .DUMP_MEM(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .ch_en(ch_en), .start_work(sw[1]),
        .end_work(end_work), .c_dump(cd[1]), .m_dump(md[1]), .busy(bz[1]), .done(dn[1]),
        .timeout(tmo[1]), .cycles_ch(cyc_b), .total_cycles(tot_b));
    run_monitor #(.N_CH(2), .CNT_W(4), .TIMEOUT(0), .DUMP_CYCLES(2), .DUMP_MEM(1)) dut_c (
        .clk(clk), .reset(reset), .start(start), .ch_en(ch_en), .start_work(sw[2]),
        .end_work(end_work), .c_dump(cd[2]), .m_dump(md[2]), .busy(bz[2]), .done(dn[2]),
        .timeout(tmo[2]), .cycles_ch(cyc_c), .total_cycles(tot_c));

    function automatic logic [31:0] get_cyc(input int d, input int i);
        if (d == 0) return cyc_a[i*32 +: 32];
        if (d == 1) return cyc_b[i*32 +: 32];
        return 32'(cyc_c[i*4 +: 4]);
    endfunction

    function automatic logic [31:0] get_tot(input int d);
        if (d == 0) return tot_a;
        if (d == 1) return tot_b;
        return 32'(tot_c);
    endfunction

    // Pulse and start_work high-time accumulated over a run.
    logic mon;
    int   n_cd [3], n_md [3], n_ovl [3];
    int   n_sw [3][2];
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!mon) begin
                n_cd[d] = 0; n_md[d] = 0; n_ovl[d] = 0; n_sw[d][0] = 0; n_sw[d][1] = 0;
            end else begin
                n_cd[d]  += int'(cd[d]);
                n_md[d]  += int'(md[d]);
                n_ovl[d] += int'(cd[d] & md[d]);
                n_sw[d][0] += int'(sw[d][0]);
                n_sw[d][1] += int'(sw[d][1]);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Run-level reference: results follow from finish cycles, timeout and counter width.
    function automatic void model(input int d, input logic [1:0] en, input int f0, input int f1,
                                  output logic [31:0] c0, output logic [31:0] c1,
                                  output logic [31:0] tot, output logic to,
                                  output int s0, output int s1);
        int f[2];
        int kmax;
        bit any, aborted;
        logic [31:0] ones, c[2];
        int s[2];
        f[0] = f0; f[1] = f1;
        ones = (W_P[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << W_P[d]) - 32'd1);
        kmax = 0; any = 0;
        for (int i = 0; i < 2; i++)
            if (en[i]) begin any = 1; if (f[i] > kmax) kmax = f[i]; end
        aborted = (TO_P[d] != 0) && any && (kmax > TO_P[d]);
        for (int i = 0; i < 2; i++) begin
            if (!en[i]) begin
                c[i] = 0; s[i] = 0;
            end else if (aborted && f[i] > TO_P[d]) begin
                c[i] = ones; s[i] = TO_P[d];
            end else begin
                c[i] = (32'(f[i]) > ones) ? ones : 32'(f[i]); s[i] = f[i];
            end
        end
        if (!any)        tot = 0;
        else if (aborted) tot = 32'(TO_P[d]);
        else             tot = (32'(kmax) > ones) ? ones : 32'(kmax);
        to = aborted;
        c0 = c[0]; c1 = c[1]; s0 = s[0]; s1 = s[1];
    endfunction

    task automatic check_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_d%0d_flags", tag, d),
                64'({sw[d], cd[d], md[d], bz[d], dn[d], tmo[d]}), 64'd0);
            chk($sformatf("%s_d%0d_cycles", tag, d), {get_cyc(d, 1), get_cyc(d, 0)}, 64'd0);
            chk($sformatf("%s_d%0d_total", tag, d), 64'(get_tot(d)), 64'd0);
        end
    endtask

    task automatic run(input logic [1:0] en, input int f0, input int f1, input bit use_tbl,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] et);
        int f[2];
        bit all;
        logic [31:0] mc0, mc1, mt;
        logic mto;
        int s0, s1;
        f[0] = f0; f[1] = f1;
        @(negedge clk);
        mon = 0; ch_en = en;
        end_work[0] = (f0 == 1); end_work[1] = (f1 == 1);
        @(negedge clk);
        mon = 1; start = 1;
        @(posedge clk);
        all = 0;
        for (int c = 1; c <= 400 && !all; c++) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!en[i] || c > f[i]) end_work[i] = 1'($urandom);
                else end_work[i] = (c == f[i]);
            end
            @(negedge clk);
            all = dn[0] & dn[1] & dn[2];
            if (!all) @(posedge clk);
        end
        chk("done_wait", 64'(all), 64'd1);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            model(d, en, f0, f1, mc0, mc1, mt, mto, s0, s1);
            chk($sformatf("d%0d_cycles0", d), 64'(get_cyc(d, 0)), 64'(mc0));
            chk($sformatf("d%0d_cycles1", d), 64'(get_cyc(d, 1)), 64'(mc1));
            chk($sformatf("d%0d_total", d), 64'(get_tot(d)), 64'(mt));
            chk($sformatf("d%0d_timeout", d), 64'(tmo[d]), 64'(mto));
            chk($sformatf("d%0d_done_busy", d), 64'({dn[d], bz[d]}), 64'b10);
            chk($sformatf("d%0d_cdump_len", d), 64'(n_cd[d]), 64'(DC_P[d]));
            chk($sformatf("d%0d_mdump_len", d), 64'(n_md[d]), 64'(DM_P[d] != 0 ? DC_P[d] : 0));
            chk($sformatf("d%0d_dump_overlap", d), 64'(n_ovl[d]), 64'd0);
            chk($sformatf("d%0d_sw0_len", d), 64'(n_sw[d][0]), 64'(s0));
            chk($sformatf("d%0d_sw1_len", d), 64'(n_sw[d][1]), 64'(s1));
        end
        if (use_tbl) begin
            chk("tbl_cycles0", 64'(get_cyc(0, 0)), 64'(e0));
            chk("tbl_cycles1", 64'(get_cyc(0, 1)), 64'(e1));
            chk("tbl_total", 64'(get_tot(0)), 64'(et));
        end
        start = 0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            model(d, en, f0, f1, mc0, mc1, mt, mto, s0, s1);
            chk($sformatf("d%0d_idle_done", d), 64'(dn[d]), 64'd0);
            chk($sformatf("d%0d_idle_held", d), {get_cyc(d, 1), get_cyc(d, 0), get_tot(d)},
                {mc1, mc0, mt});
        end
    endtask

    typedef struct {
        logic [1:0]  en;
        int          f0, f1;
        logic [31:0] c0, c1, tot;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{2'b11, 40, 57, 40, 57, 57};
        tbl[1] = '{2'b11, 1, 1, 1, 1, 1};
        tbl[2] = '{2'b11, 30, 150, 30, 150, 150};
        tbl[3] = '{2'b11, 30, 100, 30, 100, 100};
        tbl[4] = '{2'b10, 5, 12, 0, 12, 12};
        tbl[5] = '{2'b00, 9, 9, 0, 0, 0};
        tbl[6] = '{2'b01, 101, 3, 101, 0, 101};

        reset = 1; start = 0; ch_en = 0; end_work = 0; mon = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 0;

        for (int t = 0; t < 7; t++)
            run(tbl[t].en, tbl[t].f0, tbl[t].f1, 1'b1, tbl[t].c0, tbl[t].c1, tbl[t].tot);

        // Reset during RUN cycle 20, then a fresh run must count from zero.
        @(negedge clk);
        ch_en = 2'b11; end_work = 0; start = 1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        chk("midrun_sw", 64'(sw[0]), 64'd3);
        reset = 1; start = 0;
        @(posedge clk);
        @(negedge clk);
        check_zero("midrun");
        reset = 0;
        run(2'b11, 10, 15, 1'b1, 10, 15, 15);

        for (int t = 0; t < 8; t++)
            run(2'($urandom_range(0, 3)), int'($urandom_range(1, 130)),
                int'($urandom_range(1, 130)), 1'b0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
